// File: rtl/universal_shift_register.sv
// N-bit register with hold, parallel load and multi-cycle shift-left/right,
// each started by a start strobe and ended by a done pulse. USR_ROTATE_EN turns shifts into rotates.
module universal_shift_register #(
  parameter int N  = 8,
  parameter int AW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] amount,
  input  logic [N-1:0]  I,
  input  logic          sin_l,
  input  logic          sin_r,
  output logic [N-1:0]  Q,
  output logic          sout,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_LEFT  = 2'b01;
  localparam logic [1:0] M_RIGHT = 2'b10;
  localparam logic [1:0] M_LOAD  = 2'b11;

  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  q_q, q_d;
  logic          sout_q, sout_d;
  logic          done_q, done_d;
  logic          ins_l, ins_r;

`ifdef USR_ROTATE_EN
  // Rotate build: the wrapped bit replaces the serial input.
  logic unused_sin;
  assign unused_sin = sin_l ^ sin_r;
  assign ins_l = q_q[N-1];
  assign ins_r = q_q[0];
`else
  assign ins_l = sin_l;
  assign ins_r = sin_r;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= M_HOLD;
      cnt_q   <= '0;
      q_q     <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (mode)
            M_HOLD: done_d = 1'b1;
            M_LOAD: begin
              q_d    = I;
              done_d = 1'b1;
            end
            default: begin
              if (amount == '0) begin
                done_d = 1'b1;
              end else begin
                mode_d  = mode;
                cnt_d   = amount;
                state_d = SHIFT;
              end
            end
          endcase
        end
      end
      SHIFT: begin
        if (mode_q == M_LEFT) begin
          q_d    = {q_q[N-2:0], ins_l};
          sout_d = q_q[N-1];
        end else begin
          q_d    = {ins_r, q_q[N-1:1]};
          sout_d = q_q[0];
        end
        cnt_d = cnt_q - AW'(1);
        // Last shift: return to IDLE and flag completion for the next cycle.
        if (cnt_q == AW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Q    = q_q;
  assign sout = sout_q;
  assign busy = (state_q == SHIFT);
  assign done = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register (N=8): expected Q/sout pushed at start,
// popped and compared when done rises; also checks latency, busy length and reset behaviour.
module tb_universal_shift_register;

  localparam int N  = 8;
  localparam int AW = 4;

  typedef struct packed {
    logic [N-1:0] q;
    logic         sout;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, start, sin_l, sin_r;
  logic [1:0]    mode;
  logic [AW-1:0] amount;
  logic [N-1:0]  I;
  logic [N-1:0]  Q;
  logic          sout, busy, done;

  exp_t         sb[$];
  logic [N-1:0] m_q;
  logic         m_sout;
  int           vectors = 0;
  int           errs    = 0;

  universal_shift_register #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .amount(amount),
    .I(I), .sin_l(sin_l), .sin_r(sin_r), .Q(Q), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation in the current cycle and returns in the cycle done is high.
  task automatic run_op(input logic [1:0] md, input logic [AW-1:0] amt, input logic [N-1:0] din,
                        input logic sl, input logic sr, input bit poke, input string name);
    exp_t e;
    int   lat, bcnt, exp_lat, exp_busy;
    bit   clash;
    logic b;
    exp_busy = 0;
    if (md == 2'b11) m_q = din;
    if (md == 2'b01 || md == 2'b10) begin
      for (int i = 0; i < int'(amt); i++) begin
        if (md == 2'b01) begin
          b = m_q[N-1];
          m_sout = b;
`ifdef USR_ROTATE_EN
          m_q = {m_q[N-2:0], b};
`else
          m_q = {m_q[N-2:0], sl};
`endif
        end else begin
          b = m_q[0];
          m_sout = b;
`ifdef USR_ROTATE_EN
          m_q = {b, m_q[N-1:1]};
`else
          m_q = {sr, m_q[N-1:1]};
`endif
        end
      end
      exp_busy = int'(amt);
    end
    exp_lat = exp_busy + 1;
    e.q = m_q;
    e.sout = m_sout;
    sb.push_back(e);

    mode = md; amount = amt; I = din; sin_l = sl; sin_r = sr; start = 1'b1;
    step();
    start = 1'b0;
    lat = 1; bcnt = 0; clash = (busy && done);
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) bcnt++;
      if (poke && lat == 2) begin
        start = 1'b1; mode = 2'b11; I = 8'hFF;
      end else begin
        start = 1'b0; mode = md; I = din;
      end
      step();
      lat++;
      if (busy && done) clash = 1'b1;
    end
    start = 1'b0;

    e = sb.pop_front();
    vectors++;
    if (lat !== exp_lat) begin errs++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
    vectors++;
    if (bcnt !== exp_busy) begin errs++; $display("FAIL %s busy cycles: got %0d want %0d", name, bcnt, exp_busy); end
    vectors++;
    if (clash !== 1'b0) begin errs++; $display("FAIL %s busy/done overlap: got %0b want 0", name, clash); end
    vectors++;
    if (Q !== e.q) begin errs++; $display("FAIL %s Q: got %h want %h", name, Q, e.q); end
    vectors++;
    if (sout !== e.sout) begin errs++; $display("FAIL %s sout: got %b want %b", name, sout, e.sout); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; mode = 2'b11; I = 8'hA5;
    step();
    vectors++;
    if ({Q, sout, busy, done} !== 11'b0) begin
      errs++; $display("FAIL reset_state: got Q=%h sout=%b busy=%b done=%b want all 0", Q, sout, busy, done);
    end
    reset = 1'b0; start = 1'b0;
    step();
    vectors++;
    if (Q !== 8'h00 || done !== 1'b0) begin
      errs++; $display("FAIL reset_priority: got Q=%h done=%b want Q=00 done=0", Q, done);
    end
    m_q = '0; m_sout = 1'b0;
  endtask

  task automatic test_load();
    run_op(2'b11, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, "load");
    vectors++;
    if (Q !== 8'hA5) begin errs++; $display("FAIL load_value: got %h want a5", Q); end
    step();
    vectors++;
    if (done !== 1'b0) begin errs++; $display("FAIL load_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_hold();
    run_op(2'b00, 4'd5, 8'h11, 1'b1, 1'b1, 1'b0, "hold");
    step();
  endtask

  task automatic test_shift_left();
    run_op(2'b11, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, "sl_load");
    run_op(2'b01, 4'd3, 8'h00, 1'b1, 1'b0, 1'b0, "shift_left3");
`ifndef USR_ROTATE_EN
    vectors++;
    if (Q !== 8'h2F || sout !== 1'b1) begin
      errs++; $display("FAIL shift_left3_const: got Q=%h sout=%b want 2f/1", Q, sout);
    end
`endif
    step();
  endtask

  task automatic test_shift_right_zero();
    run_op(2'b11, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, "sr_load");
    run_op(2'b10, 4'd8, 8'h00, 1'b1, 1'b0, 1'b0, "shift_right8");
`ifndef USR_ROTATE_EN
    vectors++;
    if (Q !== 8'h00 || sout !== 1'b1) begin
      errs++; $display("FAIL shift_right8_const: got Q=%h sout=%b want 00/1", Q, sout);
    end
`endif
    step();
    run_op(2'b10, 4'd0, 8'hFF, 1'b1, 1'b1, 1'b0, "zero_amount");
    step();
  endtask

  task automatic test_long_shift();
    run_op(2'b11, 4'd0, 8'h5A, 1'b0, 1'b0, 1'b0, "long_load");
    run_op(2'b01, 4'd10, 8'h00, 1'b1, 1'b0, 1'b0, "shift_left10");
    step();
  endtask

  task automatic test_back_to_back();
    run_op(2'b11, 4'd0, 8'hC3, 1'b0, 1'b0, 1'b0, "b2b_load");
    run_op(2'b10, 4'd2, 8'h00, 1'b0, 1'b1, 1'b0, "b2b_right2");
    run_op(2'b01, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0, "b2b_left1");
    run_op(2'b11, 4'd0, 8'h96, 1'b0, 1'b0, 1'b0, "b2b_load2");
    step();
  endtask

  task automatic test_ignored_start();
    run_op(2'b11, 4'd0, 8'h3C, 1'b0, 1'b0, 1'b0, "ign_load");
    run_op(2'b01, 4'd5, 8'h00, 1'b0, 1'b0, 1'b1, "ignored_start");
    step();
  endtask

  task automatic test_abort();
    bit seen;
    run_op(2'b11, 4'd0, 8'h3C, 1'b0, 1'b0, 1'b0, "abort_load");
    mode = 2'b01; amount = 4'd5; sin_l = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if ({Q, sout, busy, done} !== 11'b0) begin
      errs++; $display("FAIL abort_state: got Q=%h sout=%b busy=%b done=%b want all 0", Q, sout, busy, done);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done || busy) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin errs++; $display("FAIL abort_no_done: got activity=%b want 0", seen); end
    m_q = '0; m_sout = 1'b0;
  endtask

`ifdef USR_ROTATE_EN
  task automatic test_rotate();
    run_op(2'b11, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0, "rot_load");
    run_op(2'b01, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0, "rot_left1");
    vectors++;
    if (Q !== 8'h03 || sout !== 1'b1) begin
      errs++; $display("FAIL rot_left1_const: got Q=%h sout=%b want 03/1", Q, sout);
    end
    run_op(2'b01, 4'd8, 8'h00, 1'b0, 1'b0, 1'b0, "rot_left8");
    vectors++;
    if (Q !== 8'h03) begin errs++; $display("FAIL rot_left8_const: got Q=%h want 03", Q); end
    step();
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'b00; amount = '0; I = '0; sin_l = 1'b0; sin_r = 1'b0;
    m_q = '0; m_sout = 1'b0;
    step();
    step();
    test_reset();
    test_load();
    test_hold();
    test_shift_left();
    test_shift_right_zero();
    test_long_shift();
    test_back_to_back();
    test_ignored_start();
    test_abort();
`ifdef USR_ROTATE_EN
    test_rotate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised N-bit register extending the plain load register with hold, parallel load, and multi-cycle shift-left/shift-right operations. Each operation is started by a single-cycle `start` strobe and completed with a `done` pulse. It sits in the lab datapath wherever a value must be captured, then serialised or realigned by a programmable bit count. It is the general-purpose successor to the load-only register.

## Interface

Parameters:
- `N`, default 8: register width in bits; N ≥ 2.
- `AW`, default `$clog2(N)+1`: width of `amount`; covers shift counts 0..N.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: reset is synchronous and active-high.
- `start`  input  1: begin the operation selected by `mode`; sampled only in IDLE.
- `mode`  input  2: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- `amount`  input  AW: number of single-bit shifts; used only by modes 01/10.
- `I`  input  N: parallel load data.
- `sin_l`  input  1: serial bit entering at bit 0 on a shift left.
- `sin_r`  input  1: serial bit entering at bit N-1 on a shift right.
- `Q`  output  N: register contents (registered).
- `sout`  output  1: last bit shifted out (registered).
- `busy`  output  1: high while in SHIFT state.
- `done`  output  1: one-cycle pulse, operation complete.

## Operation

- FSM states: IDLE and SHIFT. Internal registers: `mode_r` (2 bits) and down-counter `cnt_r` (AW bits).
- In IDLE with `start`=1, action at that edge depends on `mode`:
  - 00: Q unchanged; `done`=1 next cycle.
  - 11: Q ← I; `done`=1 next cycle.
  - 01/10 with `amount`=0: Q unchanged; `done`=1 next cycle; stays IDLE.
  - 01/10 with `amount`=k≥1: latch `mode_r`, set `cnt_r`←k, go to SHIFT; Q unchanged at this edge.
- In SHIFT, each edge performs one shift and decrements `cnt_r`:
  - Left: Q ← {Q[N-2:0], sin_l}; `sout` ← old Q[N-1].
  - Right: Q ← {sin_r, Q[N-1:1]}; `sout` ← old Q[0].
- The edge that shifts with `cnt_r`=1 returns the FSM to IDLE and sets `done`=1 for the next cycle.
- `start`, `mode`, `amount` and `I` are ignored while `busy`=1. `sin_l`/`sin_r` are sampled live at every shift edge.
- `amount` > N is legal: the register shifts `amount` times, and the contents are fully replaced by serial bits.
- `busy`=1 exactly while the state is SHIFT.
- `done` is registered, high for one cycle only, and never coincides with `busy`=1.

## Timing

- Reset values: Q=0, `sout`=0, `busy`=0, `done`=0, state IDLE, `cnt_r`=0.
- Reset mid-shift aborts the operation and forces the reset values above; no `done` pulse is produced.
- `reset` has priority over `start`.
- Hold, load, and zero-amount operations: `done` is high in the cycle after the start edge.
- Shift by k≥1, with the start edge counted as edge 0:
  - Shifts occur at edges 1..k.
  - `busy` is high from after edge 0 until edge k.
  - `done` is high in the cycle after edge k.
  - Total latency is k+1 cycles.
- A new `start` is accepted in the same cycle `done` is high (back-to-back operations).
- `sout` holds its value between shifts; it is not updated by load or hold.

## Configuration

- `USR_ROTATE_EN` defined: shifts become rotates.
  - Left: Q ← {Q[N-2:0], Q[N-1]}.
  - Right: Q ← {Q[0], Q[N-1:1]}.
  - `sin_l`/`sin_r` are ignored; `sout` still reports the bit that wrapped.
- `USR_ROTATE_EN` undefined: serial-input shifting as described above.
- Ports are identical in both builds.

## Test plan

All scenarios use N=8.

- Reset then idle: after `reset` pulse -> Q=8'h00, `busy`=0, `done`=0; `start` asserted together with `reset` -> no load.
- Load: `mode`=11, I=8'hA5, `start` for 1 cycle -> Q=8'hA5 after that edge; `done` high exactly 1 cycle; `busy` never high.
- Shift left 3: Q=8'hA5, `mode`=01, `amount`=3, `sin_l`=1 -> Q=8'h2F; `sout`=1; `busy` high 3 cycles; `done` 4 cycles after start.
- Shift right 8 then zero-amount: Q=8'hA5, `mode`=10, `amount`=8, `sin_r`=0 -> Q=8'h00, `sout`=1. Then `amount`=0 -> Q unchanged, `done` next cycle.
- Ignored start and abort:
  - During a 5-step shift, pulse `start` with `mode`=11 -> no load; the shift completes normally.
  - Repeat the shift with `reset` at step 2 -> Q=0, no `done`.
- `USR_ROTATE_EN` build: Q=8'h81, `mode`=01, `amount`=1 -> Q=8'h03, `sout`=1; `amount`=8 -> Q returns to its starting value.
